// File: rtl/wb_counter_bank_if.sv
// Wishbone slave bus bundle for the counter bank.
// Master drives cycle/strobe/address/data, slave returns ack and read data.
interface wb_counter_bank_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_counter_bank.sv
// Multi-channel Wishbone counter bank with compare, direction,
// one-shot mode, sticky match flags and a shared interrupt.
module wb_counter_bank #(
  parameter int BITS     = 32,
  parameter int CHANNELS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  wb_counter_bank_if.slave           bus,
  input  logic [BITS-1:0]            la_write,
  input  logic [BITS-1:0]            la_input,
  output logic [CHANNELS*BITS-1:0]   count_o,
  output logic                       irq_o
);

  logic                     valid;
  logic                     acc;
  logic [3:0]               ch;
  logic [1:0]               rsel;
  logic [31:0]              bmask;
  logic [31:0]              rdata;
  logic [CHANNELS*32-1:0]   rd_flat;
  logic [CHANNELS-1:0]      irq_vec;
  logic                     unused_ok;

  assign valid = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign acc   = valid & ~bus.wbs_ack_o;
  assign ch    = bus.wbs_adr_i[7:4];
  assign rsel  = bus.wbs_adr_i[3:2];
  assign bmask = {{8{bus.wbs_sel_i[3]}}, {8{bus.wbs_sel_i[2]}},
                  {8{bus.wbs_sel_i[1]}}, {8{bus.wbs_sel_i[0]}}};
  assign unused_ok = ^{bus.wbs_adr_i[31:8], bus.wbs_adr_i[1:0]};

  function automatic logic [BITS-1:0] merge(
    input logic [BITS-1:0] old,
    input logic [31:0]     d,
    input logic [31:0]     m
  );
    logic [31:0] w;
    w = (32'(old) & ~m) | (d & m);
    return w[BITS-1:0];
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [BITS-1:0] count_q;
    logic [BITS-1:0] cmp_q;
    logic [3:0]      ctrl_q;
    logic            match_q;
    logic            wr;
    logic            wr_cnt;
    logic            la_hit;
    logic [BITS-1:0] la_val;
    logic            evt;
    logic            step;
    logic            fire;
    logic [BITS-1:0] nxt;
    logic [31:0]     rd;

    assign wr     = acc & bus.wbs_we_i & (ch == 4'(i));
    assign wr_cnt = wr & (rsel == 2'd0);

    if (i == 0) begin : g_la
      assign la_hit = |la_write;
      assign la_val = (count_q & ~la_write) | (la_input & la_write);
    end else begin : g_nola
      assign la_hit = 1'b0;
      assign la_val = count_q;
    end

    // ctrl_q[1]: 0 counts up to compare, 1 counts down to zero
    assign evt  = ctrl_q[1] ? (count_q == '0) : (count_q == cmp_q);
    assign nxt  = ctrl_q[1] ? (evt ? cmp_q : count_q - BITS'(1))
                            : (evt ? '0 : count_q + BITS'(1));
    assign step = ctrl_q[0] & ~wr_cnt & ~la_hit;
    assign fire = step & evt;

    always_ff @(posedge clk) begin
      if (reset) begin
        count_q <= '0;
        cmp_q   <= '1;
        ctrl_q  <= '0;
        match_q <= 1'b0;
      end else begin
        if (wr_cnt)
          count_q <= merge(count_q, bus.wbs_dat_i, bmask);
        else if (la_hit)
          count_q <= la_val;
        else if (step)
          count_q <= nxt;

        if (wr && rsel == 2'd1)
          cmp_q <= merge(cmp_q, bus.wbs_dat_i, bmask);

        if (wr && rsel == 2'd2 && bus.wbs_sel_i[0])
          ctrl_q <= bus.wbs_dat_i[3:0];
        else if (fire && ctrl_q[2])
          ctrl_q[0] <= 1'b0;

        // a new match beats a same-cycle clear
        if (fire)
          match_q <= 1'b1;
        else if (wr && rsel == 2'd3 && bus.wbs_sel_i[0] && bus.wbs_dat_i[0])
          match_q <= 1'b0;
      end
    end

    always_comb begin
      rd = '0;
      unique case (rsel)
        2'd0: rd = 32'(count_q);
        2'd1: rd = 32'(cmp_q);
        2'd2: rd = 32'(ctrl_q);
        2'd3: rd = 32'(match_q);
      endcase
    end

    assign rd_flat[i*32 +: 32]     = rd;
    assign irq_vec[i]              = match_q & ctrl_q[3];
    assign count_o[i*BITS +: BITS] = count_q;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (ch == 4'(i))
        rdata = rd_flat[i*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      irq_o         <= 1'b0;
    end else begin
      bus.wbs_ack_o <= acc;
      if (acc)
        bus.wbs_dat_o <= rdata;
      irq_o <= |irq_vec;
    end
  end

endmodule
